// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - default address/instruction widths and reset PC
//   - fetch FSM state encoding (exported on the fetch_unit debug port)
//   - next-PC select encoding used between fetch_unit and fetch_pc
//   - ISA opcode constants (instr[15:12]) so neighbouring stages agree
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int          ADDR_W_DEF   = 16;
  localparam int          INSTR_W_DEF  = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'b00,
    PC_INC    = 2'b01,
    PC_TARGET = 2'b10
  } pc_sel_e;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1110;

endpackage

// File: rtl/fetch_pc.sv
// ---------------------------------------------------------------------------
// fetch_pc
// Program counter register with its next-PC mux (hold / +1 / target).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pc <= RESET_PC)
//   sel         next-PC select (PC_HOLD, PC_INC, PC_TARGET)
//   target      redirect target, used when sel == PC_TARGET
//   pc          current program counter
//   pc_inc      pc + 1, wrapping mod 2^ADDR_W
// ---------------------------------------------------------------------------
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  input  pc_sel_e           sel,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_inc
);

  logic [ADDR_W-1:0] pc_next;

  // Plain unsigned add: 'hFFFF + 1 drops the carry and wraps to 0.
  assign pc_inc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    pc_next = pc;
    case (sel)
      PC_INC:    pc_next = pc_inc;
      PC_TARGET: pc_next = target;
      default:   pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage in front of instruct_mem. Owns the PC, presents it
// as imem_addr, captures the combinational imem_instr into the IF/ID register
// and hands it to decode. Supports back-pressure, branch redirect with flush
// and a sticky halt; counts instructions delivered to decode.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   imem_addr        word address to instruct_mem (equals pc)
//   imem_instr       instruction returned by instruct_mem in the same cycle
//   redirect_valid   branch/jump taken: load redirect_target, flush IF/ID
//   redirect_target  new PC
//   halt             stop fetching; sticky until redirect or reset
//   if_valid         IF/ID holds a valid instruction
//   if_instr         fetched instruction
//   if_pc            address it was fetched from
//   if_pc_next       if_pc + 1 (wrapping)
//   id_ready         decode accepts if_* this cycle
//   fetch_cnt        count of completed IF->ID transfers (wraps)
//   fsm_state        current fetch FSM state (debug visibility)
//
// Handshake: a transfer completes on a rising edge where if_valid && id_ready.
// While if_valid && !id_ready every if_* output is held stable; the only
// exception is a redirect, which flushes the register regardless.
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF[ADDR_W-1:0]
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_next,
  input  logic               id_ready,
  output logic [15:0]        fetch_cnt,
  output fetch_state_e       fsm_state
);

  fetch_state_e      state, state_next;
  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              load;
  logic              capture;
  logic              valid_next;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (pc_sel),
    .target (redirect_target),
    .pc     (pc),
    .pc_inc (pc_inc)
  );

  assign imem_addr = pc;
  assign fsm_state = state;

  // A new instruction can enter IF/ID when fetching and the slot is empty
  // or being drained this cycle; a redirect always wins over the load.
  assign load = (state == ST_RUN) && (!if_valid || id_ready) && !redirect_valid;

  // Next-state / control. Priority: redirect, halt (RUN only), load, hold.
  always_comb begin
    state_next = state;
    pc_sel     = PC_HOLD;
    capture    = 1'b0;
    valid_next = if_valid;
    if (redirect_valid) begin
      // Flush: whatever sits in IF/ID is dropped (or was just accepted).
      pc_sel     = PC_TARGET;
      valid_next = 1'b0;
      state_next = ST_RUN;
    end else if ((state == ST_RUN) && halt) begin
      state_next = ST_HALTED;
      if (id_ready) begin
        valid_next = 1'b0;
      end
    end else if (load) begin
      capture    = 1'b1;
      valid_next = 1'b1;
      pc_sel     = PC_INC;
    end else if ((state == ST_HALTED) && id_ready) begin
      // Halted: the last held instruction still drains to decode.
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_pc_next <= '0;
    end else begin
      if_valid <= valid_next;
      if (capture) begin
        if_instr   <= imem_instr;
        if_pc      <= pc;
        if_pc_next <= pc_inc;
      end
    end
  end

  // Counts completed transfers, including the one retired on a flush edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 16'd0;
    end else if (if_valid && id_ready) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

endmodule
